// File: rtl/layer_arb_pkg.sv
// Shared types and defaults for the layer priority arbiter.
package layer_arb_pkg;

  localparam int DEF_NUM_LAYERS   = 4;
  localparam int DEF_LW           = $clog2(DEF_NUM_LAYERS);
  localparam int DEF_BLINK_FRAMES = 16;

  typedef logic [DEF_LW-1:0] layer_idx_t;

  // Rank table: entry i holds the rank of layer i (0 = highest priority).
  typedef layer_idx_t [DEF_NUM_LAYERS-1:0] rank_table_t;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } arb_state_t;

  // Identity ordering: layer i starts at rank i.
  function automatic rank_table_t default_rank();
    rank_table_t t;
    for (int i = 0; i < DEF_NUM_LAYERS; i++) begin
      t[i] = layer_idx_t'(i);
    end
    return t;
  endfunction

  localparam rank_table_t DEFAULT_RANK = default_rank();

endpackage

// File: rtl/layer_priority_select.sv
// Combinational winner search: lowest rank among masked requesters,
// plus an overlap flag when two or more requesters are present.
module layer_priority_select
  import layer_arb_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int LW         = DEF_LW
) (
  input  logic [NUM_LAYERS-1:0]    mask,
  input  logic [NUM_LAYERS*LW-1:0] ranks,
  output logic [LW-1:0]            win_idx,
  output logic                     found,
  output logic                     collision
);

  localparam int HW = $clog2(NUM_LAYERS + 1);

  logic [LW-1:0] best_rank;
  logic [HW-1:0] hits;

  // Scan every layer, keep the smallest rank seen and count requesters.
  always_comb begin
    found     = 1'b0;
    win_idx   = '0;
    best_rank = '0;
    hits      = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (mask[i]) begin
        hits = hits + HW'(1);
        if (!found || (ranks[i*LW +: LW] < best_rank)) begin
          found     = 1'b1;
          win_idx   = LW'(i);
          best_rank = ranks[i*LW +: LW];
        end
      end
    end
    collision = (hits >= HW'(2));
  end

endmodule

// File: rtl/layer_priority_arbiter.sv
// Per-pixel layer arbiter with a runtime priority table. Config writes land
// in a pending table that is copied to the active table only at frame start.
module layer_priority_arbiter
  import layer_arb_pkg::*;
#(
  parameter  int NUM_LAYERS   = DEF_NUM_LAYERS,
  parameter  int RGB_W        = 8,
  parameter  int BLINK_FRAMES = DEF_BLINK_FRAMES,
  localparam int LW           = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       drawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            bgRGB,
  input  logic                        cfgValid,
  output logic                        cfgReady,
  input  logic [LW-1:0]               cfgLayer,
  input  logic [LW-1:0]               cfgRank,
  input  logic                        cfgEnable,
  input  logic                        cfgBlink,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [LW-1:0]               winnerIdx,
  output logic                        winnerValid,
  output logic                        collision
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  arb_state_t state_reg, state_next;

  logic                  cfg_fire;
  logic                  commit;
  logic [LW-1:0]         old_rank;

  logic [LW-1:0]         pend_rank_reg  [NUM_LAYERS];
  logic [LW-1:0]         pend_rank_next [NUM_LAYERS];
  logic [LW-1:0]         act_rank_reg   [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] pend_en_reg, pend_en_next;
  logic [NUM_LAYERS-1:0] pend_blink_reg, pend_blink_next;
  logic [NUM_LAYERS-1:0] act_en_reg, act_blink_reg;
  logic [NUM_LAYERS-1:0] visible;

  logic [CW-1:0]         blink_cnt_reg;
  logic                  blink_off_reg;

  logic [NUM_LAYERS*LW-1:0] act_rank_flat;
  logic [RGB_W-1:0]         layer_rgb [NUM_LAYERS];
  logic [LW-1:0]            sel_idx;
  logic                     sel_found;
  logic                     sel_collision;

  assign cfg_fire = cfgValid && cfgReady;
  assign commit   = (state_reg == COMMIT);
  // Rank the configured layer held before this write; the displaced layer takes it.
  assign old_rank = pend_rank_reg[cfgLayer];

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      // Swap semantics keep the pending ranks a permutation at all times.
      assign pend_rank_next[gi] =
          !cfg_fire                     ? pend_rank_reg[gi] :
          (cfgLayer == LW'(gi))         ? cfgRank :
          (pend_rank_reg[gi] == cfgRank) ? old_rank :
                                          pend_rank_reg[gi];
      assign pend_en_next[gi]    = (cfg_fire && (cfgLayer == LW'(gi))) ? cfgEnable : pend_en_reg[gi];
      assign pend_blink_next[gi] = (cfg_fire && (cfgLayer == LW'(gi))) ? cfgBlink  : pend_blink_reg[gi];
      assign visible[gi]         = act_en_reg[gi] && !(act_blink_reg[gi] && blink_off_reg);
      assign act_rank_flat[gi*LW +: LW] = act_rank_reg[gi];
      assign layer_rgb[gi]       = layerRGB[gi*RGB_W +: RGB_W];
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetN) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next state and config handshake; a frame start during COMMIT is ignored.
  always_comb begin
    state_next = state_reg;
    cfgReady   = 1'b0;
    case (state_reg)
      IDLE: begin
        cfgReady = 1'b1;
        if (startOfFrame) state_next = COMMIT;
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending table takes config writes; active table follows it on commit.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        pend_rank_reg[i] <= LW'(i);
        act_rank_reg[i]  <= LW'(i);
      end
      pend_en_reg    <= '1;
      pend_blink_reg <= '0;
      act_en_reg     <= '1;
      act_blink_reg  <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        pend_rank_reg[i] <= pend_rank_next[i];
      end
      pend_en_reg    <= pend_en_next;
      pend_blink_reg <= pend_blink_next;
      if (commit) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          act_rank_reg[i] <= pend_rank_reg[i];
        end
        act_en_reg    <= pend_en_reg;
        act_blink_reg <= pend_blink_reg;
      end
    end
  end

  // Blink counter counts commits and flips the phase every BLINK_FRAMES commits.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      blink_cnt_reg <= '0;
      blink_off_reg <= 1'b0;
    end else if (commit) begin
      if (blink_cnt_reg == CW'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= '0;
        blink_off_reg <= !blink_off_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + CW'(1);
      end
    end
  end

  layer_priority_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .LW         (LW)
  ) u_select (
    .mask      (drawReq & visible),
    .ranks     (act_rank_flat),
    .win_idx   (sel_idx),
    .found     (sel_found),
    .collision (sel_collision)
  );

  // Register the arbitration result; background when nobody visible requests.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      RGBOut      <= '0;
      winnerIdx   <= '0;
      winnerValid <= 1'b0;
      collision   <= 1'b0;
    end else begin
      RGBOut      <= sel_found ? layer_rgb[sel_idx] : bgRGB;
      winnerIdx   <= sel_found ? sel_idx : '0;
      winnerValid <= sel_found;
      collision   <= sel_collision;
    end
  end

endmodule

// File: tb/tb_layer_priority_arbiter.sv
// Randomized and directed checks of layer_priority_arbiter against a
// rank-ordered list model of the priority table.
module tb_layer_priority_arbiter;

  localparam int N     = 4;
  localparam int LW    = 2;
  localparam int RGB_W = 8;
  localparam int BF    = 16;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic [N-1:0]       drawReq;
  logic [N*RGB_W-1:0] layerRGB;
  logic [RGB_W-1:0]   bgRGB;
  logic               cfgValid;
  logic               cfgReady;
  logic [LW-1:0]      cfgLayer;
  logic [LW-1:0]      cfgRank;
  logic               cfgEnable;
  logic               cfgBlink;
  logic [RGB_W-1:0]   RGBOut;
  logic [LW-1:0]      winnerIdx;
  logic               winnerValid;
  logic               collision;

  always #5 clk = ~clk;

  layer_priority_arbiter #(
    .NUM_LAYERS   (N),
    .RGB_W        (RGB_W),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .drawReq      (drawReq),
    .layerRGB     (layerRGB),
    .bgRGB        (bgRGB),
    .cfgValid     (cfgValid),
    .cfgReady     (cfgReady),
    .cfgLayer     (cfgLayer),
    .cfgRank      (cfgRank),
    .cfgEnable    (cfgEnable),
    .cfgBlink     (cfgBlink),
    .RGBOut       (RGBOut),
    .winnerIdx    (winnerIdx),
    .winnerValid  (winnerValid),
    .collision    (collision)
  );

  // Model: order[r] is the layer sitting at rank r.
  int p_order [N];
  int a_order [N];
  bit p_en [N];
  bit p_bl [N];
  bit a_en [N];
  bit a_bl [N];
  int commits;
  bit in_commit;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      p_order[i] = i;
      a_order[i] = i;
      p_en[i] = 1'b1;
      a_en[i] = 1'b1;
      p_bl[i] = 1'b0;
      a_bl[i] = 1'b0;
    end
    commits   = 0;
    in_commit = 1'b0;
  endfunction

  function automatic bit m_visible(input int l);
    bit off;
    off = ((commits / BF) % 2) == 1;
    return a_en[l] && !(a_bl[l] && off);
  endfunction

  function automatic int m_pending_rank(input int l);
    int r;
    r = 0;
    for (int k = 0; k < N; k++) if (p_order[k] == l) r = k;
    return r;
  endfunction

  function automatic void m_write(input int l, input int r, input bit en, input bit bl);
    int old;
    int other;
    old   = m_pending_rank(l);
    other = p_order[r];
    p_order[r]   = l;
    p_order[old] = other;
    p_en[l] = en;
    p_bl[l] = bl;
  endfunction

  // One clock: predict from pre-edge model state, advance model, compare after edge.
  task automatic step();
    logic [RGB_W-1:0] e_rgb;
    int  e_idx;
    bit  e_val;
    bit  e_col;
    int  hits;
    int  l;
    #1;
    check("cfgReady", {31'd0, cfgReady}, {31'd0, !in_commit});
    hits  = 0;
    e_val = 1'b0;
    e_idx = 0;
    e_rgb = bgRGB;
    for (int r = 0; r < N; r++) begin
      l = a_order[r];
      if (drawReq[l] && m_visible(l)) begin
        hits++;
        if (!e_val) begin
          e_val = 1'b1;
          e_idx = l;
          e_rgb = layerRGB[l*RGB_W +: RGB_W];
        end
      end
    end
    e_col = (hits >= 2);
    if (!resetN) begin
      m_reset();
      e_rgb = '0;
      e_idx = 0;
      e_val = 1'b0;
      e_col = 1'b0;
    end else if (in_commit) begin
      a_order   = p_order;
      a_en      = p_en;
      a_bl      = p_bl;
      commits++;
      in_commit = 1'b0;
    end else begin
      if (cfgValid) m_write(int'(cfgLayer), int'(cfgRank), cfgEnable, cfgBlink);
      if (startOfFrame) in_commit = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("RGBOut", {24'd0, RGBOut}, {24'd0, e_rgb});
    check("winnerIdx", {30'd0, winnerIdx}, e_idx);
    check("winnerValid", {31'd0, winnerValid}, {31'd0, e_val});
    check("collision", {31'd0, collision}, {31'd0, e_col});
    $display("cyc=%0d rst=%b sof=%b req=%b cfgv=%b rdy=%b rgb=%h idx=%0d v=%b col=%b",
             cyc, !resetN, startOfFrame, drawReq, cfgValid, cfgReady,
             RGBOut, winnerIdx, winnerValid, collision);
    cyc++;
  endtask

  task automatic do_write(input int l, input int r, input bit en, input bit bl);
    cfgValid  = 1'b1;
    cfgLayer  = LW'(l);
    cfgRank   = LW'(r);
    cfgEnable = en;
    cfgBlink  = bl;
    step();
    cfgValid  = 1'b0;
  endtask

  task automatic do_commit();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    drawReq      = '0;
    layerRGB     = '0;
    bgRGB        = '0;
    cfgValid     = 1'b0;
    cfgLayer     = '0;
    cfgRank      = '0;
    cfgEnable    = 1'b1;
    cfgBlink     = 1'b0;
    m_reset();
    @(negedge clk);

    // Reset state.
    step();
    step();
    check("reset_rgb", {24'd0, RGBOut}, 32'h0);
    resetN = 1'b1;

    // Two overlapping layers under identity ranking.
    drawReq  = 4'b0110;
    layerRGB = {8'h5A, 8'hE0, 8'h1C, 8'h77};
    step();
    check("plan_rgb_1c", {24'd0, RGBOut}, 32'h1C);
    check("plan_idx_1", {30'd0, winnerIdx}, 32'd1);
    check("plan_col", {31'd0, collision}, 32'd1);

    // Layer2 to rank0; old table holds through the COMMIT cycle.
    do_write(2, 0, 1'b1, 1'b0);
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
    check("commit_cycle_rgb", {24'd0, RGBOut}, 32'h1C);
    step();
    check("post_commit_rgb", {24'd0, RGBOut}, 32'hE0);
    check("post_commit_idx", {30'd0, winnerIdx}, 32'd2);

    // Disable layer1: its request falls through to background.
    do_write(1, m_pending_rank(1), 1'b0, 1'b0);
    do_commit();
    drawReq = 4'b0010;
    bgRGB   = 8'h03;
    step();
    check("disabled_rgb", {24'd0, RGBOut}, 32'h03);
    check("disabled_valid", {31'd0, winnerValid}, 32'd0);

    // Blink layer3 across more than two half-periods.
    do_write(3, m_pending_rank(3), 1'b1, 1'b1);
    drawReq = 4'b1000;
    for (int f = 0; f < 2 * BF + 3; f++) begin
      do_commit();
      step();
    end

    // Write coincident with frame start, then a write held through COMMIT.
    drawReq      = 4'b1111;
    startOfFrame = 1'b1;
    do_write(0, 0, 1'b1, 1'b0);
    startOfFrame = 1'b0;
    cfgValid  = 1'b1;
    cfgLayer  = 2'd3;
    cfgRank   = 2'd0;
    cfgEnable = 1'b1;
    cfgBlink  = 1'b0;
    step();
    step();
    cfgValid = 1'b0;
    step();
    do_commit();
    step();

    // Pending change discarded by reset before it is committed.
    do_write(1, 0, 1'b1, 1'b0);
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    do_commit();
    drawReq = 4'b0011;
    step();
    check("after_reset_idx", {30'd0, winnerIdx}, 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      drawReq      = N'($urandom);
      layerRGB     = $urandom;
      bgRGB        = RGB_W'($urandom);
      cfgValid     = ($urandom_range(0, 3) == 0);
      cfgLayer     = LW'($urandom);
      cfgRank      = LW'($urandom);
      cfgEnable    = ($urandom_range(0, 4) != 0);
      cfgBlink     = ($urandom_range(0, 2) == 0);
      startOfFrame = ($urandom_range(0, 7) == 0);
      resetN       = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
